tile_ram_scheduler: RTL and testbench
=====================================

Name: tile_ram_scheduler

Overview:
- Owns the single port of the board tile/sprite RAM.
- Shares that port between two users:
  - the display pixel fetch, driven by hdata/vdata from the vga timing block; this user has hard real-time priority inside the board window;
  - a game-logic sprite writer, served by req/ack handshake during board-window idle cycles.
- Replaces the free-running address generation in front of the RAM.
- Delivers latency-aligned pixel data plus a valid flag to the layer-select stage.

Parameters:
- WIDTH, 12, hdata/vdata width
- TILE, 50, tile edge in pixels
- BOARD_X0, 50, first board column
- BOARD_Y0, 50, first board row
- BOARD_TILES, 10, tiles per board edge
  - window is X0..X0+TILE*BOARD_TILES-1 in both axes (50..549 by default)
- ADDR_W, 16, RAM address width
- DATA_W, 32, RAM data width
- RAM_LAT, 1, cycles from ram_addr presented to ram_q valid

Ports:
- clk_vga  in  1  pixel clock
- reset  in  1  asynchronous reset, active-high
- hdata  in  WIDTH  current column
- vdata  in  WIDTH  current row
- sprite_base  in  ADDR_W  base address of sprite for current pixel, sampled with hdata
- load_done  in  1  pulse: initial sprite load finished
- wr_req  in  1  writer request, held until wr_ack
- wr_addr  in  ADDR_W  write address, stable while wr_req
- wr_data  in  DATA_W  write data, stable while wr_req
- wr_ack  out  1  one-cycle pulse, write issued this cycle
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_data  out  DATA_W  RAM write data (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_q  in  DATA_W  RAM read data
- pix_data  out  DATA_W  pixel data to layer select
- pix_valid  out  1  pix_data belongs to board window
- running  out  1  state == RUN

Behaviour:
- Reset value of every output is 0; state resets to LOAD; h_off, v_off, pipeline regs and counters reset to 0. Reset is asynchronous and takes effect mid-transaction: any pending write is dropped without ack.
- State machine:
  - LOAD: display fetch disabled, pix_valid=0; writer owns every cycle. LOAD -> RUN on load_done=1.
  - RUN: absorbing state; only reset leaves it.
- in_win = hdata and vdata both inside the window, evaluated combinationally on the inputs.
- Offset counters (no modulo hardware):
  - h_off: cleared when hdata==BOARD_X0; otherwise increments each in_win cycle, wrapping TILE-1 -> 0.
  - v_off: cleared when vdata==BOARD_Y0 and hdata==0; otherwise increments when vdata is in the window and hdata==last window column, wrapping TILE-1 -> 0.
  - The offset used for a pixel is the value matching the current hdata/vdata, so hdata==BOARD_X0 yields h_off=0.
- Port ownership for the next cycle, decided every cycle:
  - RUN and in_win: display. ram_addr <= sprite_base + v_off*TILE + h_off (truncated to ADDR_W); ram_we <= 0.
  - Otherwise, if wr_req: writer. ram_addr <= wr_addr; ram_data <= wr_data; ram_we <= 1; wr_ack <= 1 in the same registered cycle.
  - Otherwise: ram_we <= 0; ram_addr holds.
- Writer handshake:
  - wr_ack never asserts on two consecutive cycles.
  - After an ack, the writer deasserts wr_req or presents new data. The cycle after an ack is not grantable, which gives 1 write per 2 cycles maximum.
  - wr_req dropped before grant: nothing is written.
- Pixel pipeline:
  - A valid bit (RUN && in_win) is delayed 1 + RAM_LAT + 1 cycles.
  - pix_data <= ram_q, registered.
  - pix_valid accompanies it; pix_data = 0 when not valid.
  - Total latency from hdata sample to pix_data is RAM_LAT + 2 cycles.
- load_done during RUN: ignored. load_done together with wr_req in LOAD: the write is still granted that cycle.

Optional Feature:
WR_STALL_STAT_EN
- Defined:
  - Adds output wr_wait_max [15:0]: the maximum number of cycles any request waited between wr_req rise and wr_ack.
  - Uses a saturating 16-bit wait counter.
  - wr_wait_max clears on reset and when vdata==0 && hdata==0.
- Not defined: the port and the counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset asserted mid-write with wr_req held -> no wr_ack, all outputs 0, running=0; after release, the first grant behaves as in LOAD.
- LOAD, wr_req with addr=0x0123, data=0xDEADBEEF -> next cycle ram_we=1, ram_addr=0x0123, wr_ack=1; back-to-back request acked every 2nd cycle; pix_valid stays 0.
- RUN, sprite_base=2500, scan row 50 columns 50,99,100 -> ram_addr 2500, 2549, 2500; row 51 column 52 -> 2552; pix_valid high exactly RAM_LAT+2 cycles after column 50.
- RUN, wr_req raised at hdata=300/vdata=300 -> no ack while in window; ack in the cycle after hdata=550 is sampled; ram_we never 1 while display owns the port.
- Row 549 to 550 and column 549 to 550 boundaries -> v_off/h_off wrap correctly; pix_valid falls RAM_LAT+2 cycles after the last window pixel.
- WR_STALL_STAT_EN: request delayed 251 cycles by the window -> wr_wait_max=251; frame start clears it to 0.

Source files
------------

// File: rtl/tile_ram_scheduler.sv
// Single-port tile/sprite RAM scheduler: the display fetch owns the port inside the board window,
// and the req/ack sprite writer gets every other cycle. Define WR_STALL_STAT_EN to add wr_wait_max.
module tile_ram_scheduler #(
    parameter int WIDTH       = 12,
    parameter int TILE        = 50,
    parameter int BOARD_X0    = 50,
    parameter int BOARD_Y0    = 50,
    parameter int BOARD_TILES = 10,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int RAM_LAT     = 1
) (
    input  logic              clk_vga,
    input  logic              reset,
    input  logic [WIDTH-1:0]  hdata,
    input  logic [WIDTH-1:0]  vdata,
    input  logic [ADDR_W-1:0] sprite_base,
    input  logic              load_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
`ifdef WR_STALL_STAT_EN
    output logic [15:0]       wr_wait_max,
`endif
    output logic              running
);

    localparam int OFF_W = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int SPAN  = TILE * BOARD_TILES;

    localparam logic [WIDTH-1:0] X_FIRST  = WIDTH'(BOARD_X0);
    localparam logic [WIDTH-1:0] X_LAST   = WIDTH'(BOARD_X0 + SPAN - 1);
    localparam logic [WIDTH-1:0] Y_FIRST  = WIDTH'(BOARD_Y0);
    localparam logic [WIDTH-1:0] Y_LAST   = WIDTH'(BOARD_Y0 + SPAN - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(TILE - 1);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic              h_in;
    logic              v_in;
    logic              in_win;
    logic              disp_sel;
    logic              wr_grant;
    logic [OFF_W-1:0]  h_cnt;
    logic [OFF_W-1:0]  v_cnt;
    logic [OFF_W-1:0]  h_off;
    logic [OFF_W-1:0]  h_next;
    logic [OFF_W-1:0]  v_next;
    logic              row_start;
    logic              row_end;
    logic [ADDR_W-1:0] fetch_addr;
    logic [RAM_LAT:0]  valid_pipe;

    assign h_in   = (hdata >= X_FIRST) && (hdata <= X_LAST);
    assign v_in   = (vdata >= Y_FIRST) && (vdata <= Y_LAST);
    assign in_win = h_in && v_in;

    // h_cnt holds the offset of the next pixel; the first window column forces zero directly
    assign h_off     = (hdata == X_FIRST) ? '0 : h_cnt;
    assign h_next    = (h_off == OFF_LAST) ? '0 : h_off + OFF_W'(1);
    assign v_next    = (v_cnt == OFF_LAST) ? '0 : v_cnt + OFF_W'(1);
    assign row_start = (vdata == Y_FIRST) && (hdata == '0);
    assign row_end   = v_in && (hdata == X_LAST);

    assign fetch_addr = sprite_base + ADDR_W'(32'(v_cnt) * TILE) + ADDR_W'(h_off);

    assign running = (state == ST_RUN);

    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        disp_sel   = 1'b0;
        wr_grant   = 1'b0;
        case (state)
            ST_LOAD: begin
                if (load_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                disp_sel = in_win;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
        // The cycle right after an ack still shows the old request, so it is never grantable
        wr_grant = !disp_sel && wr_req && !wr_ack;
    end

    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (in_win) begin
                h_cnt <= h_next;
            end else if (hdata == X_FIRST) begin
                h_cnt <= '0;
            end
            if (row_start) begin
                v_cnt <= '0;
            end else if (row_end) begin
                v_cnt <= v_next;
            end
        end
    end

    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            ram_addr <= '0;
            ram_data <= '0;
            ram_we   <= 1'b0;
            wr_ack   <= 1'b0;
        end else begin
            ram_we <= wr_grant;
            wr_ack <= wr_grant;
            if (disp_sel) begin
                ram_addr <= fetch_addr;
            end else if (wr_grant) begin
                ram_addr <= wr_addr;
                ram_data <= wr_data;
            end
        end
    end

    // valid_pipe[RAM_LAT] lines up with ram_q for the pixel fetched RAM_LAT+1 edges earlier
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            valid_pipe <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
        end else begin
            valid_pipe[0] <= disp_sel;
            for (int i = 1; i <= RAM_LAT; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
            pix_valid <= valid_pipe[RAM_LAT];
            pix_data  <= valid_pipe[RAM_LAT] ? ram_q : '0;
        end
    end

`ifdef WR_STALL_STAT_EN
    logic [15:0] wait_cnt;
    logic [15:0] wait_now;
    logic        frame_start;

    assign frame_start = (hdata == '0) && (vdata == '0);
    assign wait_now    = (wait_cnt == 16'hFFFF) ? 16'hFFFF : wait_cnt + 16'd1;

    // wait_now counts the grant cycle itself, so an immediate grant records 1
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            wr_wait_max <= '0;
        end else begin
            if (wr_grant || !wr_req || wr_ack) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_now;
            end
            if (frame_start) begin
                wr_wait_max <= '0;
            end else if (wr_grant && (wait_now > wr_wait_max)) begin
                wr_wait_max <= wait_now;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tile_ram_scheduler.sv
// Bench for tile_ram_scheduler: directed scan rows plus a formula-based model compared every cycle.
// Build with WR_STALL_STAT_EN defined to also check wr_wait_max.
module tb_tile_ram_scheduler;

    localparam int WIDTH       = 12;
    localparam int TILE        = 50;
    localparam int BOARD_X0    = 50;
    localparam int BOARD_Y0    = 50;
    localparam int BOARD_TILES = 10;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int RAM_LAT     = 1;
    localparam int LAT         = RAM_LAT + 2;
    localparam int SPAN        = TILE * BOARD_TILES;

    logic              clk_vga = 1'b0;
    logic              reset = 1'b1;
    logic [WIDTH-1:0]  hdata = '0;
    logic [WIDTH-1:0]  vdata = '0;
    logic [ADDR_W-1:0] sprite_base = 16'd2500;
    logic              load_done = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q = '0;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              running;
`ifdef WR_STALL_STAT_EN
    logic [15:0]       wr_wait_max;
`endif

    int n_checks = 0;
    int n_errors = 0;

    tile_ram_scheduler #(
        .WIDTH(WIDTH), .TILE(TILE), .BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0),
        .BOARD_TILES(BOARD_TILES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk_vga(clk_vga),
        .reset(reset),
        .hdata(hdata),
        .vdata(vdata),
        .sprite_base(sprite_base),
        .load_done(load_done),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .ram_we(ram_we),
        .ram_q(ram_q),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
`ifdef WR_STALL_STAT_EN
        .wr_wait_max(wr_wait_max),
`endif
        .running(running)
    );

    always #5 clk_vga = ~clk_vga;

    function automatic logic [DATA_W-1:0] ram_fn(input logic [ADDR_W-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic bit in_window(input int h, input int v);
        return (h >= BOARD_X0) && (h < BOARD_X0 + SPAN) && (v >= BOARD_Y0) && (v < BOARD_Y0 + SPAN);
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base, input int h, input int v);
        int a;
        a = int'(base) + ((v - BOARD_Y0) % TILE) * TILE + ((h - BOARD_X0) % TILE);
        return ADDR_W'(a);
    endfunction

    // Single-port RAM whose content is a fixed function of the address
    always @(posedge clk_vga) begin
        ram_q <= ram_fn(ram_addr);
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: arbitration by rule, addresses by modulo arithmetic, pixels via a delay ring
    logic              m_run;
    logic              m_ack;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    int                m_cyc;
    logic              ring_v [8];
    logic [DATA_W-1:0] ring_d [8];
    logic              m_disp;
    logic              m_grant;

    assign m_disp  = m_run && in_window(int'(hdata), int'(vdata));
    assign m_grant = !m_disp && wr_req && !m_ack;

    always @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            m_run  <= 1'b0;
            m_ack  <= 1'b0;
            m_we   <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            m_cyc  <= 0;
            for (int i = 0; i < 8; i++) begin
                ring_v[i] <= 1'b0;
                ring_d[i] <= '0;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            if (load_done) m_run <= 1'b1;
            m_we  <= m_grant;
            m_ack <= m_grant;
            if (m_disp) begin
                m_addr <= pix_addr(sprite_base, int'(hdata), int'(vdata));
                ring_v[(m_cyc + LAT) % 8] <= 1'b1;
                ring_d[(m_cyc + LAT) % 8] <= ram_fn(pix_addr(sprite_base, int'(hdata), int'(vdata)));
            end else begin
                ring_v[(m_cyc + LAT) % 8] <= 1'b0;
                ring_d[(m_cyc + LAT) % 8] <= '0;
                if (m_grant) begin
                    m_addr <= wr_addr;
                    m_data <= wr_data;
                end
            end
        end
    end

`ifdef WR_STALL_STAT_EN
    int   m_max;
    int   m_start;
    logic m_pend;

    function automatic int wait_len(input logic pend, input int start, input int cyc);
        int w;
        w = pend ? (cyc - start + 1) : 1;
        return (w > 65535) ? 65535 : w;
    endfunction

    always @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            m_max   <= 0;
            m_start <= 0;
            m_pend  <= 1'b0;
        end else begin
            if (hdata == '0 && vdata == '0) begin
                m_max <= 0;
            end else if (m_grant && wait_len(m_pend, m_start, m_cyc) > m_max) begin
                m_max <= wait_len(m_pend, m_start, m_cyc);
            end
            if (m_grant) begin
                m_pend <= 1'b0;
            end else if (wr_req && !m_ack) begin
                if (!m_pend) begin
                    m_pend  <= 1'b1;
                    m_start <= m_cyc;
                end
            end else if (!wr_req) begin
                m_pend <= 1'b0;
            end
        end
    end
`endif

    // Every cycle, away from the active edge
    always @(negedge clk_vga) begin
        check_output("wr_ack",    32'(wr_ack),    32'(m_ack));
        check_output("ram_we",    32'(ram_we),    32'(m_we));
        check_output("ram_addr",  32'(ram_addr),  32'(m_addr));
        check_output("ram_data",  ram_data,       m_data);
        check_output("running",   32'(running),   32'(m_run));
        check_output("pix_valid", 32'(pix_valid), 32'(ring_v[m_cyc % 8]));
        check_output("pix_data",  pix_data,       ring_d[m_cyc % 8]);
`ifdef WR_STALL_STAT_EN
        check_output("wr_wait_max", 32'(wr_wait_max), 32'(m_max));
`endif
    end

    task automatic apply_stimulus(input int h, input int v);
        hdata = WIDTH'(h);
        vdata = WIDTH'(v);
        @(negedge clk_vga);
    endtask

    task automatic pin_checks(input int v, input int h);
        if (v == 50 && h == 50)   check_output("r50c50_addr", 32'(ram_addr), 32'd2500);
        if (v == 50 && h == 51)   check_output("r50_pix_early", 32'(pix_valid), 32'd0);
        if (v == 50 && h == 52) begin
            check_output("r50_pix_valid", 32'(pix_valid), 32'd1);
            check_output("r50_pix_data", pix_data, 32'h539EF63B);
        end
        if (v == 50 && h == 99)   check_output("r50c99_addr", 32'(ram_addr), 32'd2549);
        if (v == 50 && h == 100)  check_output("r50c100_addr", 32'(ram_addr), 32'd2500);
        if (v == 51 && h == 52)   check_output("r51c52_addr", 32'(ram_addr), 32'd2552);
        if (v == 100 && h == 500) check_output("r100c500_addr", 32'(ram_addr), 32'd2500);
        if (v == 300 && h == 549) check_output("r300_no_ack_in_win", 32'(wr_ack), 32'd0);
        if (v == 300 && h == 550) begin
            check_output("r300_ack", 32'(wr_ack), 32'd1);
            check_output("r300_we", 32'(ram_we), 32'd1);
            check_output("r300_addr", 32'(ram_addr), 32'h0200);
`ifdef WR_STALL_STAT_EN
            check_output("r300_wait_max", 32'(wr_wait_max), 32'd251);
`endif
        end
        if (v == 548 && h == 50)  check_output("r548c50_addr", 32'(ram_addr), 32'd4900);
        if (v == 549 && h == 549) check_output("r549c549_addr", 32'(ram_addr), 32'd4999);
        if (v == 549 && h == 551) check_output("r549_pix_last", 32'(pix_valid), 32'd1);
        if (v == 549 && h == 552) check_output("r549_pix_fall", 32'(pix_valid), 32'd0);
        if (v == 550 && h == 52)  check_output("r550_pix", 32'(pix_valid), 32'd0);
    endtask

    task automatic scan_row(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            if (v == 300 && h == 300) begin
                wr_req  = 1'b1;
                wr_addr = 16'h0200;
                wr_data = 32'hCAFEF00D;
            end
            apply_stimulus(h, v);
            if (wr_ack) wr_req = 1'b0;
            pin_checks(v, h);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (2) @(negedge clk_vga);
        check_output("reset_running", 32'(running), 32'd0);
        check_output("reset_ack", 32'(wr_ack), 32'd0);
        reset = 1'b0;

        // LOAD: writer owns the port even inside the window
        wr_req  = 1'b1;
        wr_addr = 16'h0123;
        wr_data = 32'hDEADBEEF;
        apply_stimulus(300, 300);
        check_output("load_we", 32'(ram_we), 32'd1);
        check_output("load_addr", 32'(ram_addr), 32'h0123);
        check_output("load_data", ram_data, 32'hDEADBEEF);
        check_output("load_ack", 32'(wr_ack), 32'd1);
        wr_addr = 16'h0124;
        wr_data = 32'h00000001;
        apply_stimulus(300, 300);
        check_output("b2b_gap_ack", 32'(wr_ack), 32'd0);
        apply_stimulus(301, 300);
        check_output("b2b_ack", 32'(wr_ack), 32'd1);
        check_output("b2b_addr", 32'(ram_addr), 32'h0124);
        wr_req = 1'b0;
        apply_stimulus(302, 300);
        check_output("idle_addr_hold", 32'(ram_addr), 32'h0124);
        check_output("load_pix", 32'(pix_valid), 32'd0);

        // Reset lands between request and grant
        wr_req  = 1'b1;
        wr_addr = 16'h0055;
        wr_data = 32'h00000055;
        #2 reset = 1'b1;
        @(negedge clk_vga);
        check_output("rst_mid_ack", 32'(wr_ack), 32'd0);
        check_output("rst_mid_addr", 32'(ram_addr), 32'd0);
        check_output("rst_mid_data", ram_data, 32'd0);
        reset = 1'b0;
        apply_stimulus(10, 10);
        check_output("post_rst_ack", 32'(wr_ack), 32'd1);
        check_output("post_rst_addr", 32'(ram_addr), 32'h0055);
        wr_req = 1'b0;
        apply_stimulus(10, 10);

        // load_done and a write in the same cycle
        wr_req    = 1'b1;
        wr_addr   = 16'h0066;
        wr_data   = 32'h00000066;
        load_done = 1'b1;
        apply_stimulus(10, 10);
        check_output("ld_ack", 32'(wr_ack), 32'd1);
        check_output("ld_addr", 32'(ram_addr), 32'h0066);
        check_output("ld_running", 32'(running), 32'd1);
        wr_req    = 1'b0;
        load_done = 1'b0;
        apply_stimulus(11, 10);

        scan_row(50, 0, 560);
        scan_row(51, 45, 560);
        for (int v = 52; v <= 547; v++) begin
            if (v == 300) scan_row(v, 300, 560);
            else scan_row(v, 500, 549);
        end
        for (int v = 548; v <= 551; v++) begin
            scan_row(v, 45, 560);
        end

        // load_done after RUN is ignored; frame start clears the stall statistic
        load_done = 1'b1;
        apply_stimulus(0, 0);
        load_done = 1'b0;
        check_output("frame_running", 32'(running), 32'd1);
`ifdef WR_STALL_STAT_EN
        check_output("frame_clear", 32'(wr_wait_max), 32'd0);
`endif
        apply_stimulus(1, 0);
        apply_stimulus(2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
